// File: rtl/nco_sweep_ctrl.sv
// Stepped linear frequency-sweep controller for the phase-accumulator tuning word M.
// Supports a single up-sweep or a continuous up/down triangle with per-step dwell.
module nco_sweep_ctrl #(
    parameter int WIDTH = 32,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] f_start,
    input  logic [WIDTH-1:0] f_step,
    input  logic [CW-1:0]    n_steps,
    input  logic [CW-1:0]    dwell,
    output logic [WIDTH-1:0] M,
    output logic             busy,
    output logic             done,
    output logic             dir
);

    // state | meaning
    // IDLE  | waiting for start; M holds last value (0 after reset/abort)
    // RUN   | sweep active; dwell timer and step counter advancing
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] step_l_q, step_l_d;
    logic [CW-1:0]    nsteps_l_q, nsteps_l_d;
    logic [CW-1:0]    dwell_l_q, dwell_l_d;
    logic             mode_l_q, mode_l_d;
    logic [CW-1:0]    step_cnt_q, step_cnt_d;
    logic [CW-1:0]    dwell_cnt_q, dwell_cnt_d;
    logic             done_q, done_d;
    logic             dir_q, dir_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            m_q         <= '0;
            step_l_q    <= '0;
            nsteps_l_q  <= '0;
            dwell_l_q   <= '0;
            mode_l_q    <= 1'b0;
            step_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            done_q      <= 1'b0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            step_l_q    <= step_l_d;
            nsteps_l_q  <= nsteps_l_d;
            dwell_l_q   <= dwell_l_d;
            mode_l_q    <= mode_l_d;
            step_cnt_q  <= step_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            done_q      <= done_d;
            dir_q       <= dir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        step_l_d    = step_l_q;
        nsteps_l_d  = nsteps_l_q;
        dwell_l_d   = dwell_l_q;
        mode_l_d    = mode_l_q;
        step_cnt_d  = step_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        done_d      = 1'b0;
        dir_d       = dir_q;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    step_l_d    = f_step;
                    nsteps_l_d  = n_steps;
                    dwell_l_d   = dwell;
                    mode_l_d    = mode;
                    m_d         = f_start;
                    dir_d       = 1'b0;
                    step_cnt_d  = '0;
                    dwell_cnt_d = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                // Abort takes priority over any dwell expiry in the same cycle.
                if (stop) begin
                    m_d         = '0;
                    dir_d       = 1'b0;
                    step_cnt_d  = '0;
                    dwell_cnt_d = '0;
                    state_d     = IDLE;
                end else if (dwell_cnt_q == dwell_l_q) begin
                    dwell_cnt_d = '0;
                    if (step_cnt_q < nsteps_l_q) begin
                        m_d        = dir_q ? (m_q - step_l_q) : (m_q + step_l_q);
                        step_cnt_d = step_cnt_q + 1'b1;
                    end else if (!mode_l_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        dir_d      = ~dir_q;
                        step_cnt_d = '0;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign M    = m_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
    assign dir  = dir_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: an elapsed-time sweep model predicts outputs per
// edge into a queue; a negedge monitor pops and compares against the DUT.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_step = '0;
    logic [15:0] n_steps = '0;
    logic [15:0] dwell = '0;
    logic [31:0] M;
    logic        busy, done, dir;

    nco_sweep_ctrl #(.WIDTH(32), .CW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
        .M(M), .busy(busy), .done(done), .dir(dir)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] m;
        logic        busy;
        logic        done;
        logic        dir;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: outputs as a function of clocks elapsed since the start edge.
    bit          act = 0;
    int          t = 0;
    logic [31:0] mf, ms, em = '0;
    int          mn, md;
    bit          mmode;
    bit          edir = 0, edone = 0;

    always @(posedge clk or negedge reset) begin
        int hold, leg_len, leg, pos;
        exp_t e;
        if (!reset) begin
            act = 0; em = '0; edir = 0; edone = 0; t = 0;
        end else if (!act) begin
            edone = 0;
            if (start && !stop) begin
                act = 1; t = 0;
                mf = f_start; ms = f_step; mn = int'(n_steps); md = int'(dwell); mmode = mode;
                em = f_start; edir = 0;
            end
        end else if (stop) begin
            act = 0; em = '0; edir = 0; edone = 0;
        end else begin
            t++;
            edone = 0;
            hold = md + 1;
            leg_len = (mn + 1) * hold;
            if (!mmode) begin
                if (t == leg_len) begin
                    act = 0; edone = 1;
                end else begin
                    em = mf + ms * 32'(t / hold);
                end
            end else begin
                leg  = t / leg_len;
                pos  = (t % leg_len) / hold;
                edir = leg[0];
                em   = edir ? mf + ms * 32'(mn - pos) : mf + ms * 32'(pos);
            end
        end
        if (clk === 1'b1) begin
            e.m = em; e.busy = act; e.done = edone; e.dir = edir;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({M, busy, done, dir} !== {e.m, e.busy, e.done, e.dir}) begin
                errors++;
                $display("FAIL outputs @%0t: got M=%h busy=%b done=%b dir=%b, exp M=%h busy=%b done=%b dir=%b",
                         $time, M, busy, done, dir, e.m, e.busy, e.done, e.dir);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setp(input logic [31:0] fs, input logic [31:0] st, input int n, input int d, input bit md_i);
        f_start = fs; f_step = st; n_steps = 16'(n); dwell = 16'(d); mode = md_i;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(1); stop = 1'b0;
    endtask

    initial begin
        cyc(3);
        reset = 1'b1;
        cyc(2);

        // single sweep
        setp(32'h0100_0000, 32'h0010_0000, 3, 1, 1'b0);
        pulse_start();
        cyc(12);

        // triangle
        setp(32'd100, 32'd10, 2, 0, 1'b1);
        pulse_start();
        cyc(20);
        pulse_stop();
        cyc(2);

        // wrap-around
        setp(32'hFFFF_FFF0, 32'h20, 1, 0, 1'b0);
        pulse_start();
        cyc(6);

        // abort, then fresh start
        setp(32'h0000_1000, 32'h10, 10, 3, 1'b0);
        pulse_start();
        cyc(4);
        pulse_stop();
        cyc(1);
        pulse_start();
        cyc(10);
        pulse_stop();
        cyc(2);

        // ignored start while busy, mid-sweep input changes, start+stop in idle
        setp(32'h0000_2000, 32'h100, 4, 2, 1'b0);
        pulse_start();
        cyc(2);
        f_step = 32'h5555; f_start = 32'h7777; n_steps = 16'd1; dwell = 16'd0; mode = 1'b1;
        pulse_start();
        cyc(3);
        pulse_start();
        cyc(15);
        start = 1'b1; stop = 1'b1; cyc(2); start = 1'b0; stop = 1'b0;
        cyc(3);

        // n_steps = 0 in both modes
        setp(32'h42, 32'h1, 0, 2, 1'b0);
        pulse_start();
        cyc(6);
        setp(32'h43, 32'h1, 0, 1, 1'b1);
        pulse_start();
        cyc(9);
        pulse_stop();

        // asynchronous reset mid-sweep
        setp(32'hABCD_0000, 32'h10, 8, 2, 1'b0);
        pulse_start();
        cyc(4);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (M !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || dir !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got M=%h busy=%b done=%b dir=%b, exp all zero", M, busy, done, dir);
        end
        cyc(2);
        reset = 1'b1;
        cyc(4);

        // randomized traffic
        repeat (3000) begin
            start   = ($urandom % 6) == 0;
            stop    = ($urandom % 30) == 0;
            mode    = 1'($urandom % 2);
            f_start = $urandom;
            f_step  = $urandom;
            n_steps = 16'($urandom % 5);
            dwell   = 16'($urandom % 4);
            cyc(1);
        end
        start = 1'b0; stop = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
